eth_measurer_ctrl: RTL

ETH_MEASURER_CTRL -- requirements
Module: eth_measurer_ctrl

---
 rtl/eth_measurer_pkg.sv | 24 ++
 rtl/eth_measurer_timer.sv | 33 +++
 rtl/eth_measurer_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/eth_measurer_pkg.sv
// Shared types, constants and saturating/wrapping helpers for the ping-latency measurer.
package eth_measurer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_ECHO = 3'd2,
    REPORT    = 3'd3,
    HOLDOFF   = 3'd4
  } state_e;

  localparam logic [63:0] PING_ID_INVALID = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [31:0] CNT_MAX         = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

  // The receiver idles at all-ones, so that ID is skipped to keep it from ever matching.
  function automatic logic [63:0] next_ping_id(input logic [63:0] id);
    return (id == PING_ID_INVALID - 64'd1) ? 64'd0 : id + 64'd1;
  endfunction

endpackage

// File: rtl/eth_measurer_timer.sv
// Launch-to-launch period timer: load clears the count and latches the limit.
module eth_measurer_timer
  import eth_measurer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        elapsed
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] lim_q, lim_d;

  always_comb begin
    cnt_d = load ? 32'd0 : sat_inc(cnt_q);
    lim_d = load ? load_val : lim_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

  // Count is 0 in the launch cycle, so a launch granted now lands cnt+1 cycles after the last one.
  assign elapsed = ({1'b0, cnt_q} + 33'd1) >= {1'b0, lim_q};

endmodule

// File: rtl/eth_measurer_ctrl.sv
// Ping scheduler: launches numbered pings, waits for a stable echo or timeout, reports latency.
module eth_measurer_ctrl
  import eth_measurer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic [31:0] timeout,
  output logic        tx_req,
  input  logic        tx_ack,
  output logic [63:0] tx_ping_id,
  input  logic [63:0] rx_ping_id,
  output logic        res_valid,
  output logic        res_lost,
  output logic [31:0] res_latency,
  output logic [63:0] res_ping_id,
  output logic [31:0] sent_count,
  output logic [31:0] lost_count,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [63:0] tx_ping_id_q, tx_ping_id_d;
  logic [63:0] rx_prev_q, rx_prev_d;
  logic [31:0] lat_q, lat_d;
  logic [31:0] timeout_q, timeout_d;
  logic [31:0] sent_q, sent_d;
  logic [31:0] lost_q, lost_d;
  logic        res_valid_q, res_valid_d;
  logic        res_lost_q, res_lost_d;
  logic [31:0] res_latency_q, res_latency_d;
  logic [63:0] res_ping_id_q, res_ping_id_d;
  logic        launch;
  logic        match;
  logic        period_elapsed;

  eth_measurer_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (launch),
    .load_val (period),
    .elapsed  (period_elapsed)
  );

  // Two equal consecutive samples reject a multi-bit value caught mid-update.
  assign match = (rx_ping_id == tx_ping_id_q) && (rx_prev_q == tx_ping_id_q);

  always_comb begin
    state_d       = state_q;
    tx_ping_id_d  = tx_ping_id_q;
    rx_prev_d     = rx_ping_id;
    lat_d         = lat_q;
    timeout_d     = timeout_q;
    sent_d        = sent_q;
    lost_d        = lost_q;
    res_valid_d   = 1'b0;
    res_lost_d    = res_lost_q;
    res_latency_d = res_latency_q;
    res_ping_id_d = res_ping_id_q;
    launch        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SEND;
          launch  = 1'b1;
        end
      end
      SEND: begin
        if (tx_ack) begin
          state_d = WAIT_ECHO;
          lat_d   = '0;
        end
      end
      WAIT_ECHO: begin
        lat_d = sat_inc(lat_q);
        if (match || (lat_q == timeout_q)) begin
          state_d       = REPORT;
          res_valid_d   = 1'b1;
          res_lost_d    = !match;
          res_latency_d = lat_q;
          res_ping_id_d = tx_ping_id_q;
          if (!match) lost_d = sat_inc(lost_q);
        end
      end
      REPORT: begin
        state_d      = HOLDOFF;
        tx_ping_id_d = next_ping_id(tx_ping_id_q);
      end
      HOLDOFF: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (period_elapsed) begin
          state_d = SEND;
          launch  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Launch is registered on the edge that enters SEND.
    if (launch) begin
      timeout_d = timeout;
      sent_d    = sat_inc(sent_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tx_ping_id_q  <= '0;
      rx_prev_q     <= PING_ID_INVALID;
      lat_q         <= '0;
      timeout_q     <= '0;
      sent_q        <= '0;
      lost_q        <= '0;
      res_valid_q   <= 1'b0;
      res_lost_q    <= 1'b0;
      res_latency_q <= '0;
      res_ping_id_q <= '0;
    end else begin
      state_q       <= state_d;
      tx_ping_id_q  <= tx_ping_id_d;
      rx_prev_q     <= rx_prev_d;
      lat_q         <= lat_d;
      timeout_q     <= timeout_d;
      sent_q        <= sent_d;
      lost_q        <= lost_d;
      res_valid_q   <= res_valid_d;
      res_lost_q    <= res_lost_d;
      res_latency_q <= res_latency_d;
      res_ping_id_q <= res_ping_id_d;
    end
  end

  assign tx_req      = (state_q == SEND);
  assign busy        = (state_q != IDLE);
  assign tx_ping_id  = tx_ping_id_q;
  assign res_valid   = res_valid_q;
  assign res_lost    = res_lost_q;
  assign res_latency = res_latency_q;
  assign res_ping_id = res_ping_id_q;
  assign sent_count  = sent_q;
  assign lost_count  = lost_q;

endmodule
